// File: rtl/pipe_pkg.sv
// Shared widths and control-word layout for the pipeline stage register.
package pipe_pkg;

   localparam int unsigned PIPE_DATA_W = 64;
   localparam int unsigned PIPE_CTRL_W = 12;
   localparam int unsigned PIPE_CNT_W  = 16;

   // Single-bit control flags within the control word.
   localparam int unsigned REGWRITE   = 0;
   localparam int unsigned MEMTOREG   = 1;
   localparam int unsigned MEMREAD    = 2;
   localparam int unsigned MEMWRITE   = 3;
   localparam int unsigned BRANCH     = 4;
   localparam int unsigned PC_REGREAD = 5;

   // Multi-bit control fields.
   localparam int unsigned ALUOP_LSB  = 6;
   localparam int unsigned ALUOP_MSB  = 9;
   localparam int unsigned IRLAST_LSB = 10;
   localparam int unsigned IRLAST_MSB = 11;

   typedef struct packed {
      logic [IRLAST_MSB-IRLAST_LSB:0] irlast;
      logic [ALUOP_MSB-ALUOP_LSB:0]   aluop;
      logic                           pc_regread;
      logic                           branch;
      logic                           memwrite;
      logic                           memread;
      logic                           memtoreg;
      logic                           regwrite;
   } ctrl_t;

endpackage

// File: rtl/pipe_stage_reg_if.sv
// Upstream/downstream handshake bundle of one pipeline stage register.
interface pipe_stage_reg_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W
);

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic [CTRL_W-1:0] in_ctrl;
   logic              flush;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;
   logic [CTRL_W-1:0] out_ctrl;

   // Environment side: drives the upstream word and the downstream ready.
   modport master (
      output in_valid, in_data, in_ctrl, flush, out_ready,
      input  in_ready, out_valid, out_data, out_ctrl
   );

   // Stage side.
   modport slave (
      input  in_valid, in_data, in_ctrl, flush, out_ready,
      output in_ready, out_valid, out_data, out_ctrl
   );

endinterface

// File: rtl/pipe_skid_buf.sv
// Single-entry skid register holding a word accepted while the main entry stalls.
module pipe_skid_buf
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              clr,
   input  logic              load,
   input  logic              unload,
   input  logic [DATA_W-1:0] wr_data,
   input  logic [CTRL_W-1:0] wr_ctrl,
   output logic              valid,
   output logic [DATA_W-1:0] data,
   output logic [CTRL_W-1:0] ctrl
);

   // Load wins over unload so a drain and refill in one edge keeps the entry full.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid <= 1'b0;
         data  <= '0;
         ctrl  <= '0;
      end else if (clr) begin
         valid <= 1'b0;
      end else if (load) begin
         valid <= 1'b1;
         data  <= wr_data;
         ctrl  <= wr_ctrl;
      end else if (unload) begin
         valid <= 1'b0;
      end
   end

endmodule

// File: rtl/pipe_stage_reg.sv
// Valid/ready pipeline stage register with flush and saturating stall counter.
// Optional second (skid) entry and registered in_ready under PIPE_STAGE_SKID_EN.
module pipe_stage_reg
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = PIPE_DATA_W,
   parameter int unsigned CTRL_W = PIPE_CTRL_W,
   parameter int unsigned CNT_W  = PIPE_CNT_W
) (
   input  logic             clk,
   input  logic             rst,
   pipe_stage_reg_if.slave  bus,
   output logic [CNT_W-1:0] stall_cnt
);

   logic              main_valid;
   logic [DATA_W-1:0] main_data;
   logic [CTRL_W-1:0] main_ctrl;
   logic              nxt_valid;
   logic [DATA_W-1:0] nxt_data;
   logic [CTRL_W-1:0] nxt_ctrl;

   logic              accept;
   logic              main_free;
   logic              src_valid;
   logic [DATA_W-1:0] src_data;
   logic [CTRL_W-1:0] src_ctrl;

   assign main_free = !main_valid || bus.out_ready;
   assign accept    = bus.in_valid && bus.in_ready && !bus.flush;

`ifdef PIPE_STAGE_SKID_EN
   logic              skid_valid;
   logic [DATA_W-1:0] skid_data;
   logic [CTRL_W-1:0] skid_ctrl;

   // in_ready only reflects skid occupancy, so accept implies an empty skid entry.
   assign bus.in_ready = !skid_valid;

   pipe_skid_buf #(
      .DATA_W (DATA_W),
      .CTRL_W (CTRL_W)
   ) u_skid (
      .clk     (clk),
      .rst     (rst),
      .clr     (bus.flush),
      .load    (accept && !main_free),
      .unload  (main_free && skid_valid),
      .wr_data (bus.in_data),
      .wr_ctrl (bus.in_ctrl),
      .valid   (skid_valid),
      .data    (skid_data),
      .ctrl    (skid_ctrl)
   );

   // Older skid word goes first to keep FIFO order.
   assign src_valid = skid_valid || accept;
   assign src_data  = skid_valid ? skid_data : bus.in_data;
   assign src_ctrl  = skid_valid ? skid_ctrl : bus.in_ctrl;
`else
   assign bus.in_ready = main_free;
   assign src_valid    = accept;
   assign src_data     = bus.in_data;
   assign src_ctrl     = bus.in_ctrl;
`endif

   // Main entry next state; ctrl is zeroed whenever the entry empties so bubbles are NOPs.
   always_comb begin
      nxt_valid = main_valid;
      nxt_data  = main_data;
      nxt_ctrl  = main_ctrl;
      if (bus.flush) begin
         nxt_valid = 1'b0;
         nxt_ctrl  = '0;
      end else if (main_free) begin
         if (src_valid) begin
            nxt_valid = 1'b1;
            nxt_data  = src_data;
            nxt_ctrl  = src_ctrl;
         end else begin
            nxt_valid = 1'b0;
            nxt_ctrl  = '0;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         main_valid <= 1'b0;
         main_data  <= '0;
         main_ctrl  <= '0;
      end else begin
         main_valid <= nxt_valid;
         main_data  <= nxt_data;
         main_ctrl  <= nxt_ctrl;
      end
   end

   // Saturating count of edges where a held word is blocked downstream.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_cnt <= '0;
      end else if (main_valid && !bus.out_ready && (stall_cnt != '1)) begin
         stall_cnt <= stall_cnt + CNT_W'(1);
      end
   end

   assign bus.out_valid = main_valid;
   assign bus.out_data  = main_data;
   assign bus.out_ctrl  = main_ctrl;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 64, width of the payload word (alu_result, reg2data, pc, npc and imm packed).
REQ-002 SHALL have parameter CTRL_W, default 12, width of the control word (regwrite, memtoreg, memread, memwrite, branch, pc_regread, aluop, irlast).
REQ-003 SHALL have parameter CNT_W, default 16, width of the stall counter.
REQ-004 SHALL use one clock and a reset that is synchronous and active-high.
REQ-005 SHALL have port clk, input, 1, rising-edge clock.
REQ-006 SHALL have port rst, input, 1, synchronous active-high reset.
REQ-007 SHALL have port in_valid, input, 1, upstream stage holds a valid instruction.
REQ-008 SHALL have port in_ready, output, 1, stage accepts the input this cycle.
REQ-009 SHALL have port in_data, input, DATA_W, upstream payload.
REQ-010 SHALL have port in_ctrl, input, CTRL_W, upstream control word.
REQ-011 SHALL have port flush, input, 1, squash request from branch resolution.
REQ-012 SHALL have port out_valid, output, 1, stage holds a valid instruction.
REQ-013 SHALL have port out_ready, input, 1, downstream stage consumes this cycle.
REQ-014 SHALL have port out_data, output, DATA_W, registered payload.
REQ-015 SHALL have port out_ctrl, output, CTRL_W, registered control word.
REQ-016 SHALL have port stall_cnt, output, CNT_W, saturating count of downstream-stall cycles.

Function
REQ-017 SHALL accept a transfer on a rising edge when in_valid && in_ready && !flush; the accepted word SHALL appear on out_data/out_ctrl with out_valid=1 one cycle later (latency 1).
REQ-018 SHALL complete an output transfer on a rising edge when out_valid && out_ready; if no new word is accepted in that cycle, out_valid SHALL be 0 on the next cycle.
REQ-019 SHALL hold out_valid, out_data and out_ctrl stable while out_valid && !out_ready.
REQ-020 SHALL drive out_ctrl to all-zero whenever out_valid=0, so that a bubble behaves as a NOP; out_data SHALL keep its last value.
REQ-021 SHALL, on a flush cycle, clear every stored valid bit on the next edge and discard any in_valid word presented in that cycle; flush SHALL take priority over accept and hold.
REQ-022 SHALL increment stall_cnt on every edge where out_valid && !out_ready; it SHALL saturate at 2^CNT_W-1 and SHALL NOT wrap.
REQ-023 SHALL, when accept and output transfer occur in the same edge, load the new word with out_valid staying 1 (no bubble).

Reset
REQ-024 SHALL, with rst=1 at an edge, set out_valid=0, out_data=0, out_ctrl=0, stall_cnt=0 and empty all internal storage; rst SHALL override flush and in_valid.
REQ-025 SHALL present in_ready=1 in the first cycle after rst deasserts.

Configuration
REQ-026 SHALL compile a second (skid) entry only when macro PIPE_STAGE_SKID_EN is defined.
REQ-027 SHALL, without PIPE_STAGE_SKID_EN, drive in_ready = !out_valid || out_ready (combinational), with a single register entry.
REQ-028 SHALL, with PIPE_STAGE_SKID_EN, drive in_ready from a register (in_ready = skid entry empty), so that it has no combinational path from out_ready.
REQ-029 SHALL, with PIPE_STAGE_SKID_EN, store a word accepted while out_valid && !out_ready into the skid entry.
REQ-030 SHALL, with PIPE_STAGE_SKID_EN, move the skid entry into the main entry on the next output transfer, preserving FIFO order and sustaining one word per cycle.

Structure
REQ-031 SHALL take default widths, ctrl bit-index constants (REGWRITE, MEMTOREG, MEMREAD, MEMWRITE, BRANCH, PC_REGREAD) and aluop/irlast field ranges from shared package pipe_pkg.
REQ-032 SHALL implement the skid entry as sub-module pipe_skid_buf, instantiated only under PIPE_STAGE_SKID_EN.

Verification
REQ-033 SHALL cover: in_valid=1 with data 0x1234, out_ready=1 -> out_data=0x1234 and out_valid=1 exactly one cycle later.
REQ-034 SHALL cover: out_ready=0 for 5 cycles with a word held -> output stable and stall_cnt=5; with CNT_W=2, 5 stall cycles -> stall_cnt=3.
REQ-035 SHALL cover: flush asserted with one word held and in_valid=1 -> next cycle out_valid=0 and out_ctrl=0, and neither word ever appears on the output.
REQ-036 SHALL cover: rst asserted mid-stream with a full skid entry -> all outputs zero and in_ready=1 after release.
REQ-037 SHALL cover: with skid enabled, a back-to-back stream 1..8 with out_ready toggling every cycle -> all 8 words delivered in order, none lost or duplicated.
